alu_mem_unit: RTL and testbench
===============================

Name: alu_mem_unit

Overview:
- Execute/memory block of the multicycle CPU.
- Bundles three pieces:
  - a 32-bit ALU with a 4-bit operation select and an equality flag;
  - a word-addressed instruction memory (IMem) with combinational read and a loader write port;
  - a word-addressed data memory (DMem) with synchronous write and combinational read.
- A registered copy of the ALU result (alu_out) feeds the datapath's IorD mux and register-file write-back.

Parameters:
- IMEM_DEPTH, 256, number of 32-bit instruction words (power of 2).
- DMEM_DEPTH, 256, number of 32-bit data words (power of 2).

Ports:
- clk  in  1  single system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- alu_a  in  32  ALU operand A.
- alu_b  in  32  ALU operand B.
- alu_sel  in  4  operation select (opcode[3:0]).
- alu_result  out  32  combinational ALU result.
- alu_eq  out  1  combinational, 1 when alu_a == alu_b.
- alu_ovf  out  1  signed overflow flag (see Optional Feature).
- alu_out  out  32  registered alu_result.
- imem_addr  in  32  instruction word address.
- imem_data  out  32  combinational instruction word.
- imem_we  in  1  loader write enable.
- imem_waddr  in  32  loader word address.
- imem_wdata  in  32  loader data.
- dmem_addr  in  16  data word address.
- dmem_wdata  in  32  store data.
- dmem_we  in  1  store enable (MemWrite).
- dmem_rdata  out  32  combinational load data.

Behaviour:
- ALU (combinational), by alu_sel:
  - 0 MOV: A.
  - 1 NOT: ~A.
  - 2 ADD: A+B.
  - 3 SUB: A-B.
  - 4 OR: A|B.
  - 5 AND: A&B.
  - 6 XOR: A^B.
  - 7 SLT: signed A<B gives 32'd1, else 0.
  - 8-15: result 0.
- ALU arithmetic wraps modulo 2^32; no carry output.
- alu_eq is independent of alu_sel. The datapath uses it for BEQ (sel source 0) and BNE (inverted).
- alu_out: on posedge clk it loads alu_result every cycle, with no enable. It resets to 0.
- IMem read: imem_data = mem[imem_addr mod IMEM_DEPTH], combinational; upper address bits are ignored (wrap).
- IMem write: on posedge clk, if imem_we, mem[imem_waddr mod IMEM_DEPTH] <= imem_wdata.
  - A read of the same address in the same cycle returns the old word until the edge.
  - IMem contents are not affected by rst_n; the power-up contents are 0.
- DMem read: dmem_rdata = mem[dmem_addr mod DMEM_DEPTH], combinational.
- DMem write: on posedge clk, if dmem_we, mem[dmem_addr mod DMEM_DEPTH] <= dmem_wdata.
  - Read-during-write returns the old data before the edge and the new data after it.
- DMem reset: rst_n low asynchronously clears every DMem word to 0 and alu_out to 0.
  - Writes are ignored while rst_n is low.
  - Reset asserted mid-operation overrides a coincident write.
- No handshakes; every access is single-cycle.

Optional Feature:
- Macro: ALU_OVF_EN.
- Defined: alu_ovf = 1 on signed overflow.
  - ADD: overflow when the operands have the same sign and the result sign differs.
  - SUB: overflow when the operands have different signs and the result sign differs from A.
  - All other ops: alu_ovf = 0.
- Not defined: alu_ovf is tied to 0 and the overflow logic is absent.

Test Plan:
- ALU ops, A=0x0000000F, B=0x00000003:
  - sel 0..7 give 0xF, 0xFFFFFFF0, 0x12, 0xC, 0xF, 0x3, 0xC, 0x0.
  - sel 7 with A=0xFFFFFFFF, B=1 gives 1.
  - sel 9 gives 0.
- alu_eq: A=B=0x1234 gives eq=1; A=0x1234, B=0x1235 gives eq=0. Check with sel=0 and sel=3; eq is the same regardless of sel.
- alu_out: with sel=2, A=5, B=7, alu_out becomes 12 after one rising edge. Pulsing rst_n low between edges clears alu_out to 0 immediately, without waiting for an edge.
- IMem wrap: write 0xDEADBEEF at waddr 3; then imem_addr 3 returns 0xDEADBEEF, and imem_addr 3+IMEM_DEPTH also returns 0xDEADBEEF.
- DMem:
  - Store 0xA5A5A5A5 at addr 0x0010 with dmem_we=1; rdata is the old value (0) before the edge and 0xA5A5A5A5 after it.
  - With dmem_we=0 and a new wdata, rdata stays 0xA5A5A5A5.
  - rst_n low clears addr 0x0010 to 0.
- ALU_OVF_EN defined:
  - ADD 0x7FFFFFFF+1 gives result 0x80000000, ovf=1.
  - SUB 0x80000000-1 gives ovf=1.
  - ADD 1+1 gives ovf=0.
  - Without the macro, ovf=0 in all three cases.

Source files
------------

// File: rtl/alu_mem_unit_if.sv
// Bus bundle for alu_mem_unit: ALU operands/results, IMem fetch/loader
// port and DMem load/store port.
interface alu_mem_unit_if;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_sel;
    logic [31:0] alu_result;
    logic        alu_eq;
    logic        alu_ovf;
    logic [31:0] alu_out;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        imem_we;
    logic [31:0] imem_waddr;
    logic [31:0] imem_wdata;
    logic [15:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_we;
    logic [31:0] dmem_rdata;

    modport master (
        output alu_a, alu_b, alu_sel,
        output imem_addr, imem_we, imem_waddr, imem_wdata,
        output dmem_addr, dmem_wdata, dmem_we,
        input  alu_result, alu_eq, alu_ovf, alu_out,
        input  imem_data, dmem_rdata
    );

    modport slave (
        input  alu_a, alu_b, alu_sel,
        input  imem_addr, imem_we, imem_waddr, imem_wdata,
        input  dmem_addr, dmem_wdata, dmem_we,
        output alu_result, alu_eq, alu_ovf, alu_out,
        output imem_data, dmem_rdata
    );
endinterface

// File: rtl/alu_mem_unit.sv
// Execute/memory block: ALU, registered alu_out, IMem and DMem.
// Define ALU_OVF_EN to enable the signed overflow flag on ADD/SUB.
module alu_mem_unit #(
    parameter int IMEM_DEPTH = 256,
    parameter int DMEM_DEPTH = 256
) (
    input logic clk,
    input logic rst_n,
    alu_mem_unit_if.slave bus
);
    localparam int IAW = $clog2(IMEM_DEPTH);
    localparam int DAW = $clog2(DMEM_DEPTH);

    logic [31:0] result;
    logic [31:0] imem [IMEM_DEPTH];
    logic [31:0] dmem [DMEM_DEPTH];
    logic [IAW-1:0] iridx;
    logic [IAW-1:0] iwidx;
    logic [DAW-1:0] didx;

    // Addresses wrap: only the low index bits select a word.
    assign iridx = bus.imem_addr[IAW-1:0];
    assign iwidx = bus.imem_waddr[IAW-1:0];
    assign didx  = bus.dmem_addr[DAW-1:0];

    logic unused_bits;
    assign unused_bits = ^{bus.imem_addr[31:IAW],
                           bus.imem_waddr[31:IAW],
                           bus.dmem_addr[15:DAW]};

    always_comb begin
        result = '0;
        unique case (bus.alu_sel)
            4'd0: result = bus.alu_a;
            4'd1: result = ~bus.alu_a;
            4'd2: result = bus.alu_a + bus.alu_b;
            4'd3: result = bus.alu_a - bus.alu_b;
            4'd4: result = bus.alu_a | bus.alu_b;
            4'd5: result = bus.alu_a & bus.alu_b;
            4'd6: result = bus.alu_a ^ bus.alu_b;
            4'd7: result = {31'd0,
                            $signed(bus.alu_a) < $signed(bus.alu_b)};
            default: result = '0;
        endcase
    end

    assign bus.alu_result = result;
    assign bus.alu_eq     = (bus.alu_a == bus.alu_b);

`ifdef ALU_OVF_EN
    logic ovf;
    always_comb begin
        ovf = 1'b0;
        unique case (bus.alu_sel)
            4'd2: ovf = (bus.alu_a[31] == bus.alu_b[31]) &&
                        (result[31] != bus.alu_a[31]);
            4'd3: ovf = (bus.alu_a[31] != bus.alu_b[31]) &&
                        (result[31] != bus.alu_a[31]);
            default: ovf = 1'b0;
        endcase
    end
    assign bus.alu_ovf = ovf;
`else
    assign bus.alu_ovf = 1'b0;
`endif

    logic [31:0] alu_out_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_out_q <= '0;
        end else begin
            alu_out_q <= result;
        end
    end
    assign bus.alu_out = alu_out_q;

    // IMem is loader-owned and deliberately survives reset.
    always_ff @(posedge clk) begin
        if (bus.imem_we) begin
            imem[iwidx] <= bus.imem_wdata;
        end
    end
    assign bus.imem_data = imem[iridx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DMEM_DEPTH; i++) begin
                dmem[i] <= '0;
            end
        end else if (bus.dmem_we) begin
            dmem[didx] <= bus.dmem_wdata;
        end
    end
    assign bus.dmem_rdata = dmem[didx];
endmodule

// File: tb/tb_alu_mem_unit.sv
// Self-checking bench for alu_mem_unit: directed vectors plus
// randomized ALU and DMem traffic against a behavioural model.
module tb_alu_mem_unit;
    localparam int IDEPTH = 256;
    localparam int DDEPTH = 256;

    logic clk;
    logic rst_n;
    int   checks;
    int   passed;
    logic [31:0] dm_model [DDEPTH];

    alu_mem_unit_if bus ();

    alu_mem_unit #(
        .IMEM_DEPTH(IDEPTH),
        .DMEM_DEPTH(DDEPTH)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ref_alu(input logic [3:0] sel,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        int sa;
        int sb;
        longint unsigned w;
        sa = a;
        sb = b;
        case (sel)
            4'd0: return a;
            4'd1: return 32'hFFFF_FFFF - a;
            4'd2: begin
                w = longint'(a) + longint'(b);
                return w[31:0];
            end
            4'd3: begin
                w = longint'(a) + 64'h1_0000_0000 - longint'(b);
                return w[31:0];
            end
            4'd4: return a | b;
            4'd5: return a & b;
            4'd6: return a ^ b;
            4'd7: return (sa < sb) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic ref_ovf(input logic [3:0] sel,
                                     input logic [31:0] a,
                                     input logic [31:0] b);
`ifdef ALU_OVF_EN
        int sa;
        int sb;
        longint r;
        sa = a;
        sb = b;
        if (sel == 4'd2) r = longint'(sa) + longint'(sb);
        else if (sel == 4'd3) r = longint'(sa) - longint'(sb);
        else return 1'b0;
        return (r > 64'sd2147483647) || (r < -64'sd2147483648);
`else
        return (sel == 4'd15) && (a == b) && (a != a);
`endif
    endfunction

    task automatic note(input bit ok, input string name,
                        input logic [31:0] got,
                        input logic [31:0] exp);
        checks++;
        if (ok) passed++;
        else $display("FAIL %s: got %08h expected %08h",
                      name, got, exp);
    endtask

    task automatic clear_model();
        for (int i = 0; i < DDEPTH; i++) dm_model[i] = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        bus.alu_a = 32'd9;
        bus.alu_b = 32'd1;
        bus.alu_sel = 4'd2;
        bus.imem_addr = '0;
        bus.imem_we = 1'b0;
        bus.imem_waddr = '0;
        bus.imem_wdata = '0;
        bus.dmem_addr = 16'h0010;
        bus.dmem_wdata = '0;
        bus.dmem_we = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        clear_model();
        #1;
        if (bus.alu_out !== 32'd0)
            note(0, "reset_alu_out", bus.alu_out, 32'd0);
        else note(1, "", 0, 0);
        if (bus.dmem_rdata !== 32'd0)
            note(0, "reset_dmem", bus.dmem_rdata, 32'd0);
        else note(1, "", 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_alu_vectors();
        logic [31:0] exp [8];
        exp = '{32'hF, 32'hFFFF_FFF0, 32'h12, 32'hC,
                32'hF, 32'h3, 32'hC, 32'h0};
        @(negedge clk);
        bus.alu_a = 32'hF;
        bus.alu_b = 32'h3;
        for (int s = 0; s < 8; s++) begin
            bus.alu_sel = 4'(s);
            #1;
            if (bus.alu_result !== exp[s])
                note(0, $sformatf("alu_vec_sel%0d", s),
                     bus.alu_result, exp[s]);
            else note(1, "", 0, 0);
        end
        bus.alu_sel = 4'd7;
        bus.alu_a = 32'hFFFF_FFFF;
        bus.alu_b = 32'd1;
        #1;
        if (bus.alu_result !== 32'd1)
            note(0, "alu_slt_neg", bus.alu_result, 32'd1);
        else note(1, "", 0, 0);
        bus.alu_sel = 4'd9;
        #1;
        if (bus.alu_result !== 32'd0)
            note(0, "alu_sel9", bus.alu_result, 32'd0);
        else note(1, "", 0, 0);
    endtask

    task automatic test_eq();
        logic [3:0] sels [2];
        sels = '{4'd0, 4'd3};
        for (int k = 0; k < 2; k++) begin
            bus.alu_sel = sels[k];
            bus.alu_a = 32'h1234;
            bus.alu_b = 32'h1234;
            #1;
            if (bus.alu_eq !== 1'b1)
                note(0, "eq_equal", 32'(bus.alu_eq), 32'd1);
            else note(1, "", 0, 0);
            bus.alu_b = 32'h1235;
            #1;
            if (bus.alu_eq !== 1'b0)
                note(0, "eq_differ", 32'(bus.alu_eq), 32'd0);
            else note(1, "", 0, 0);
        end
    endtask

    task automatic test_alu_out();
        @(negedge clk);
        bus.alu_sel = 4'd2;
        bus.alu_a = 32'd5;
        bus.alu_b = 32'd7;
        @(posedge clk);
        #1;
        if (bus.alu_out !== 32'd12)
            note(0, "alu_out_load", bus.alu_out, 32'd12);
        else note(1, "", 0, 0);
        #1 rst_n = 1'b0;
        clear_model();
        #1;
        if (bus.alu_out !== 32'd0)
            note(0, "alu_out_async_rst", bus.alu_out, 32'd0);
        else note(1, "", 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_alu_random();
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  s;
        logic [31:0] r;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            a = $urandom;
            b = (n % 5 == 0) ? a : $urandom;
            if (n % 7 == 0) a = {1'b0, 31'h7FFF_FFFF} + a[0];
            s = 4'($urandom_range(0, 15));
            bus.alu_a = a;
            bus.alu_b = b;
            bus.alu_sel = s;
            r = ref_alu(s, a, b);
            #1;
            if (bus.alu_result !== r)
                note(0, $sformatf("rand_result_sel%0d", s),
                     bus.alu_result, r);
            else note(1, "", 0, 0);
            if (bus.alu_eq !== (a == b))
                note(0, "rand_eq", 32'(bus.alu_eq), 32'(a == b));
            else note(1, "", 0, 0);
            if (bus.alu_ovf !== ref_ovf(s, a, b))
                note(0, "rand_ovf", 32'(bus.alu_ovf),
                     32'(ref_ovf(s, a, b)));
            else note(1, "", 0, 0);
            @(posedge clk);
            #1;
            if (bus.alu_out !== r)
                note(0, "rand_alu_out", bus.alu_out, r);
            else note(1, "", 0, 0);
        end
    endtask

    task automatic test_ovf();
        logic [31:0] av [3];
        logic [31:0] bv [3];
        logic [3:0]  sv [3];
        logic        ev [3];
        av = '{32'h7FFF_FFFF, 32'h8000_0000, 32'd1};
        bv = '{32'd1, 32'd1, 32'd1};
        sv = '{4'd2, 4'd3, 4'd2};
`ifdef ALU_OVF_EN
        ev = '{1'b1, 1'b1, 1'b0};
`else
        ev = '{1'b0, 1'b0, 1'b0};
`endif
        for (int k = 0; k < 3; k++) begin
            bus.alu_a = av[k];
            bus.alu_b = bv[k];
            bus.alu_sel = sv[k];
            #1;
            if (bus.alu_ovf !== ev[k])
                note(0, $sformatf("ovf_case%0d", k),
                     32'(bus.alu_ovf), 32'(ev[k]));
            else note(1, "", 0, 0);
        end
        bus.alu_a = 32'h7FFF_FFFF;
        bus.alu_sel = 4'd2;
        #1;
        if (bus.alu_result !== 32'h8000_0000)
            note(0, "ovf_add_result", bus.alu_result, 32'h8000_0000);
        else note(1, "", 0, 0);
    endtask

    task automatic test_imem();
        @(negedge clk);
        bus.imem_we = 1'b1;
        bus.imem_waddr = 32'd3;
        bus.imem_wdata = 32'h1111_1111;
        @(negedge clk);
        bus.imem_wdata = 32'hDEAD_BEEF;
        bus.imem_addr = 32'd3;
        #1;
        if (bus.imem_data !== 32'h1111_1111)
            note(0, "imem_old_before_edge", bus.imem_data,
                 32'h1111_1111);
        else note(1, "", 0, 0);
        @(negedge clk);
        bus.imem_we = 1'b0;
        #1;
        if (bus.imem_data !== 32'hDEAD_BEEF)
            note(0, "imem_read", bus.imem_data, 32'hDEAD_BEEF);
        else note(1, "", 0, 0);
        bus.imem_addr = 32'd3 + IDEPTH;
        #1;
        if (bus.imem_data !== 32'hDEAD_BEEF)
            note(0, "imem_wrap", bus.imem_data, 32'hDEAD_BEEF);
        else note(1, "", 0, 0);
    endtask

    task automatic test_dmem();
        @(negedge clk);
        bus.dmem_addr = 16'h0010;
        bus.dmem_wdata = 32'hA5A5_A5A5;
        bus.dmem_we = 1'b1;
        #1;
        if (bus.dmem_rdata !== 32'd0)
            note(0, "dmem_old", bus.dmem_rdata, 32'd0);
        else note(1, "", 0, 0);
        @(posedge clk);
        #1;
        if (bus.dmem_rdata !== 32'hA5A5_A5A5)
            note(0, "dmem_new", bus.dmem_rdata, 32'hA5A5_A5A5);
        else note(1, "", 0, 0);
        @(negedge clk);
        bus.dmem_we = 1'b0;
        bus.dmem_wdata = 32'h5A5A_5A5A;
        @(posedge clk);
        #1;
        if (bus.dmem_rdata !== 32'hA5A5_A5A5)
            note(0, "dmem_no_we", bus.dmem_rdata, 32'hA5A5_A5A5);
        else note(1, "", 0, 0);
        @(negedge clk);
        rst_n = 1'b0;
        clear_model();
        #1;
        if (bus.dmem_rdata !== 32'd0)
            note(0, "dmem_rst_clear", bus.dmem_rdata, 32'd0);
        else note(1, "", 0, 0);
        bus.dmem_we = 1'b1;
        @(posedge clk);
        #1;
        if (bus.dmem_rdata !== 32'd0)
            note(0, "dmem_we_in_rst", bus.dmem_rdata, 32'd0);
        else note(1, "", 0, 0);
        @(negedge clk);
        bus.dmem_we = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_dmem_random();
        logic [15:0] ad;
        logic [31:0] wd;
        logic        we;
        int          ix;
        for (int n = 0; n < 80; n++) begin
            @(negedge clk);
            ad = (n < 40) ? 16'($urandom_range(0, 15))
                          : 16'($urandom);
            wd = $urandom;
            we = 1'($urandom_range(0, 1));
            ix = int'(ad) % DDEPTH;
            bus.dmem_addr = ad;
            bus.dmem_wdata = wd;
            bus.dmem_we = we;
            #1;
            if (bus.dmem_rdata !== dm_model[ix])
                note(0, "dmem_rand_pre", bus.dmem_rdata, dm_model[ix]);
            else note(1, "", 0, 0);
            @(posedge clk);
            if (we) dm_model[ix] = wd;
            #1;
            if (bus.dmem_rdata !== dm_model[ix])
                note(0, "dmem_rand_post", bus.dmem_rdata, dm_model[ix]);
            else note(1, "", 0, 0);
        end
        @(negedge clk);
        bus.dmem_we = 1'b0;
    endtask

    initial begin
        checks = 0;
        passed = 0;
        test_reset();
        test_alu_vectors();
        test_eq();
        test_alu_out();
        test_ovf();
        test_alu_random();
        test_imem();
        test_dmem();
        test_dmem_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
